basic_mem_subsys: RTL and testbench
===================================

# basic_mem_subsys

Unified 64×16 instruction/data memory for the basic processor, with a built-in boot loader. It sits directly below the processor's memory port: it answers processor reads combinationally, commits writes, and holds the processor in reset while a program is cleared and loaded in through a valid/ready stream. After loading it releases the processor and counts committed writes.

## Interface
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, word width.
- DATA_BASE, 32, first data-region address; addresses below it form the instruction region.
- i_clk  in  1  system clock, all flops on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ldStart  in  1  pulse: begin clear + load sequence.
- i_ldValid  in  1  loader word valid.
- i_ldData  in  DATA_W  loader word.
- i_ldLast  in  1  qualifies the final loader word.
- o_ldReady  out  1  loader may transfer.
- i_memAddr  in  ADDR_W  processor address (processor o_memAddr).
- i_memWrData  in  DATA_W  processor write data (processor o_memData).
- i_memWrEnable  in  1  processor write strobe.
- o_memData  out  DATA_W  read data to processor i_memData.
- o_procRst  out  1  active-high reset to processor i_rst.
- o_wrCount  out  8  committed processor writes, saturating.
- o_wrViol  out  1  sticky guard violation (see Configuration).

## Operation
- FSM states: IDLE, CLEAR, LOAD, RUN.
- Reset values: state=IDLE, o_procRst=1, o_ldReady=0, o_wrCount=0, o_wrViol=0, clear/load pointer=0. Array contents are not reset.
- IDLE: waits for i_ldStart, then goes to CLEAR with pointer=0.
- CLEAR: writes 0 to mem[ptr] each cycle and increments ptr. After writing address DEPTH-1, it goes to LOAD with ptr=0. Takes exactly DEPTH cycles.
- LOAD: o_ldReady=1. A transfer occurs on an edge with i_ldValid && o_ldReady. It writes i_ldData to mem[ptr] and increments ptr. A transfer with i_ldLast=1, or a transfer at ptr=DEPTH-1, moves to RUN. Unloaded words remain 0, which is the HALT encoding.
- RUN:
  - o_procRst=0.
  - o_memData = mem[i_memAddr] combinationally.
  - On an edge with i_memWrEnable=1, mem[i_memAddr] <= i_memWrData and o_wrCount increments, saturating at 255.
- o_memData = 0 in every state except RUN.
- i_ldStart in any state other than IDLE:
  - Goes to CLEAR with ptr=0 and o_wrCount=0.
  - Takes priority over a same-cycle load transfer or processor write; that word or write is dropped.
- o_procRst is a flop. It is 1 whenever the next state is not RUN, so it falls on the same edge the FSM enters RUN and rises on the edge the FSM leaves RUN.
- i_memWrEnable outside RUN is ignored.
- Pointer arithmetic is ADDR_W bits. No wrap occurs because the DEPTH-1 transitions end CLEAR and LOAD first.

## Timing
- Read latency 0 cycles (combinational from i_memAddr and the array).
- Write visible on o_memData the cycle after the write edge.
- Load: one word per cycle maximum. After the final transfer edge, the processor is out of reset in the next cycle.
- Full sequence (i_ldStart to RUN) with N words and no stalls: 1 + DEPTH + N edges.
- Asynchronous reset mid-CLEAR or mid-LOAD:
  - Returns immediately to IDLE with o_procRst=1.
  - Partially written contents are kept; only a new i_ldStart re-clears them.

## Configuration
- MEM_WR_GUARD_EN defined:
  - A RUN-state write with i_memAddr < DATA_BASE is dropped; memory is unchanged and o_wrCount does not increment.
  - o_wrViol is set and stays 1 until reset or i_ldStart.
- MEM_WR_GUARD_EN undefined:
  - All RUN writes commit.
  - o_wrViol is tied to 0.

## Test plan
- Reset, i_ldStart, 64 clear cycles, then load 3 words 0x8820/0x0860/0x0000 with last on word 3:
  - o_procRst falls 68 edges after start.
  - Reading addresses 0..2 returns the loaded words; address 3 reads 0.
- Loader stalls (i_ldValid low for 5 cycles between words): ptr holds, no spurious writes, RUN entry is delayed by exactly 5 cycles.
- In RUN, write 0x1234 to address 40:
  - o_memData at address 40 reads 0x1234 next cycle.
  - o_wrCount=1.
  - 300 further writes saturate o_wrCount at 255.
- i_ldStart asserted during RUN with a simultaneous write:
  - Write is dropped and o_procRst rises.
  - The array is fully zero after CLEAR; o_wrCount=0.
- i_rst_n pulled low at load word 2:
  - IDLE and o_procRst=1 immediately.
  - Word 1 is retained; a new start re-clears it to 0.
- With MEM_WR_GUARD_EN, write to address 5:
  - mem[5] is unchanged and o_wrViol=1.
  - Without the macro, mem[5] takes the write data and o_wrViol stays 0.

Source files
------------

// File: rtl/basic_mem_subsys_if.sv
// Bus bundle between the basic processor/boot-loader side and basic_mem_subsys.
//   Loader stream : ldValid, ldData, ldLast (to memory), ldReady (from memory)
//   Memory port   : memAddr, memWrData, memWrEnable (to memory), memData (from memory)
// master modport: processor/loader side. slave modport: memory subsystem.
interface basic_mem_subsys_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16
) ();
  logic              ldValid;
  logic [DATA_W-1:0] ldData;
  logic              ldLast;
  logic              ldReady;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrData;
  logic              memWrEnable;
  logic [DATA_W-1:0] memData;

  modport master (
    output ldValid, ldData, ldLast, memAddr, memWrData, memWrEnable,
    input  ldReady, memData
  );

  modport slave (
    input  ldValid, ldData, ldLast, memAddr, memWrData, memWrEnable,
    output ldReady, memData
  );
endinterface

// File: rtl/basic_mem_subsys.sv
// basic_mem_subsys: unified 2**ADDR_W x DATA_W instruction/data memory with boot loader.
// Holds the processor in reset while the array is cleared and a program is streamed in,
// then serves combinational reads and committed writes, counting the writes.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_ldStart      : pulse, (re)starts clear + load
//   bus            : loader stream and processor memory port (basic_mem_subsys_if.slave)
//   o_procRst      : active-high processor reset (registered)
//   o_wrCount      : committed processor writes, saturating at 255
//   o_wrViol       : sticky write-guard violation
// Optional feature: define MEM_WR_GUARD_EN to drop RUN writes below DATA_BASE and flag them
// on o_wrViol. Without it all RUN writes commit and o_wrViol stays 0.
module basic_mem_subsys #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DATA_BASE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ldStart,
  basic_mem_subsys_if.slave    bus,
  output logic                 o_procRst,
  output logic [7:0]           o_wrCount,
  output logic                 o_wrViol
);

  localparam int unsigned       DEPTH        = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PtrMax       = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DataBaseAddr = ADDR_W'(DATA_BASE);

`ifdef MEM_WR_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              proc_rst_q, proc_rst_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              wr_viol_q, wr_viol_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              guard_hit;

  assign guard_hit = GuardEn && (bus.memAddr < DataBaseAddr);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_count_d = wr_count_q;
    wr_viol_d  = wr_viol_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = '0;

    if (i_ldStart) begin
      // A restart wins over any same-cycle load word or processor write.
      state_d    = StClear;
      ptr_d      = '0;
      wr_count_d = '0;
      wr_viol_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StClear: begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = '0;
          if (ptr_q == PtrMax) begin
            state_d = StLoad;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        StLoad: begin
          if (bus.ldValid) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = bus.ldData;
            if (bus.ldLast || (ptr_q == PtrMax)) begin
              state_d = StRun;
              ptr_d   = '0;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.memWrEnable) begin
            if (guard_hit) begin
              wr_viol_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = bus.memAddr;
              mem_wdata = bus.memWrData;
              if (wr_count_q != 8'hFF) begin
                wr_count_d = wr_count_q + 8'd1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Registered so it tracks the state the FSM is about to be in.
    proc_rst_d = (state_d != StRun);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      proc_rst_q <= 1'b1;
      wr_count_q <= '0;
      wr_viol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      proc_rst_q <= proc_rst_d;
      wr_count_q <= wr_count_d;
      wr_viol_q  <= wr_viol_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ldReady = (state_q == StLoad);
  assign bus.memData = (state_q == StRun) ? mem_q[bus.memAddr] : '0;
  assign o_procRst   = proc_rst_q;
  assign o_wrCount   = wr_count_q;
  assign o_wrViol    = wr_viol_q;

endmodule

// File: tb/tb_basic_mem_subsys.sv
module tb_basic_mem_subsys;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_ldStart;
  logic       o_procRst;
  logic [7:0] o_wrCount;
  logic       o_wrViol;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  basic_mem_subsys_if #(.ADDR_W(6), .DATA_W(16)) bus ();

  basic_mem_subsys #(
    .ADDR_W   (6),
    .DATA_W   (16),
    .DATA_BASE(32)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_ldStart(i_ldStart),
    .bus      (bus),
    .o_procRst(o_procRst),
    .o_wrCount(o_wrCount),
    .o_wrViol (o_wrViol)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
    edges++;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [15:0] exp, input string tag);
    bus.memAddr = addr;
    #1;
    check(tag, {16'h0, bus.memData}, {16'h0, exp});
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    bus.ldValid = 1'b1;
    bus.ldData  = d;
    bus.ldLast  = last;
    tick();
    bus.ldValid = 1'b0;
    bus.ldLast  = 1'b0;
  endtask

  task automatic start_and_clear();
    i_ldStart = 1'b1;
    edges     = 0;
    tick();
    i_ldStart = 1'b0;
    for (int i = 0; i < 64; i++) tick();
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_ldStart       = 1'b0;
    bus.ldValid     = 1'b0;
    bus.ldData      = '0;
    bus.ldLast      = 1'b0;
    bus.memAddr     = '0;
    bus.memWrData   = '0;
    bus.memWrEnable = 1'b0;
    #12;
    check("rst_procRst", {31'h0, o_procRst}, 32'd1);
    check("rst_ldReady", {31'h0, bus.ldReady}, 32'd0);
    check("rst_wrCount", {24'h0, o_wrCount}, 32'd0);
    check("rst_wrViol",  {31'h0, o_wrViol}, 32'd0);
    check("rst_memData", {16'h0, bus.memData}, 32'd0);
    i_rst_n = 1'b1;
    tick();
    check("idle_procRst", {31'h0, o_procRst}, 32'd1);

    // Program 1: three words, no stalls.
    i_ldStart = 1'b1;
    edges     = 0;
    tick();
    i_ldStart = 1'b0;
    check("clear_ldReady", {31'h0, bus.ldReady}, 32'd0);
    for (int i = 0; i < 63; i++) tick();
    check("clear_end_ldReady", {31'h0, bus.ldReady}, 32'd0);
    tick();
    check("load_ldReady", {31'h0, bus.ldReady}, 32'd1);
    check("load_procRst", {31'h0, o_procRst}, 32'd1);
    load_word(16'h8820, 1'b0);
    load_word(16'h0860, 1'b0);
    check("pre_last_procRst", {31'h0, o_procRst}, 32'd1);
    load_word(16'h0000, 1'b1);
    check("run_procRst", {31'h0, o_procRst}, 32'd0);
    check("run_edges", edges, 32'd68);
    check("run_ldReady", {31'h0, bus.ldReady}, 32'd0);
    rd(6'd0, 16'h8820, "p1_addr0");
    rd(6'd1, 16'h0860, "p1_addr1");
    rd(6'd2, 16'h0000, "p1_addr2");
    rd(6'd3, 16'h0000, "p1_addr3");
    rd(6'd40, 16'h0000, "p1_addr40_pre");

    // RUN writes.
    @(negedge i_clk);
    bus.memAddr     = 6'd40;
    bus.memWrData   = 16'h1234;
    bus.memWrEnable = 1'b1;
    tick();
    bus.memWrEnable = 1'b0;
    rd(6'd40, 16'h1234, "wr40_data");
    check("wr40_count", {24'h0, o_wrCount}, 32'd1);

    @(negedge i_clk);
    bus.memAddr     = 6'd5;
    bus.memWrData   = 16'hBEEF;
    bus.memWrEnable = 1'b1;
    tick();
    bus.memWrEnable = 1'b0;
`ifdef MEM_WR_GUARD_EN
    rd(6'd5, 16'h0000, "guard_addr5");
    check("guard_viol", {31'h0, o_wrViol}, 32'd1);
    check("guard_count", {24'h0, o_wrCount}, 32'd1);
`else
    rd(6'd5, 16'hBEEF, "noguard_addr5");
    check("noguard_viol", {31'h0, o_wrViol}, 32'd0);
    check("noguard_count", {24'h0, o_wrCount}, 32'd2);
`endif

    @(negedge i_clk);
    bus.memAddr     = 6'd41;
    bus.memWrEnable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.memWrData = 16'(i);
      tick();
    end
    bus.memWrEnable = 1'b0;
    check("sat_count", {24'h0, o_wrCount}, 32'd255);
    rd(6'd41, 16'd299, "sat_addr41");

    // Restart during RUN with a simultaneous write that must be dropped.
    @(negedge i_clk);
    bus.memAddr     = 6'd40;
    bus.memWrData   = 16'hFFFF;
    bus.memWrEnable = 1'b1;
    i_ldStart       = 1'b1;
    edges           = 0;
    tick();
    i_ldStart       = 1'b0;
    bus.memWrEnable = 1'b0;
    check("restart_procRst", {31'h0, o_procRst}, 32'd1);
    check("restart_count", {24'h0, o_wrCount}, 32'd0);
    check("restart_viol", {31'h0, o_wrViol}, 32'd0);
    check("restart_memData", {16'h0, bus.memData}, 32'd0);
    for (int i = 0; i < 64; i++) tick();
    check("p2_ldReady", {31'h0, bus.ldReady}, 32'd1);

    // Program 2: two words with a 5-cycle stall between them.
    load_word(16'hAAAA, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("stall_ldReady", {31'h0, bus.ldReady}, 32'd1);
    check("stall_procRst", {31'h0, o_procRst}, 32'd1);
    load_word(16'h5555, 1'b1);
    check("p2_procRst", {31'h0, o_procRst}, 32'd0);
    check("p2_edges", edges, 32'd72);
    check("p2_count", {24'h0, o_wrCount}, 32'd0);
    rd(6'd0, 16'hAAAA, "p2_addr0");
    rd(6'd1, 16'h5555, "p2_addr1");
    for (int a = 2; a < 64; a++) begin
      rd(6'(a), 16'h0000, $sformatf("p2_zero%0d", a));
    end

    // Asynchronous reset while the second load word is presented.
    @(negedge i_clk);
    start_and_clear();
    load_word(16'h1111, 1'b0);
    bus.ldValid = 1'b1;
    bus.ldData  = 16'h2222;
    i_rst_n     = 1'b0;
    #1;
    check("arst_procRst", {31'h0, o_procRst}, 32'd1);
    check("arst_ldReady", {31'h0, bus.ldReady}, 32'd0);
    check("arst_memData", {16'h0, bus.memData}, 32'd0);
    check("arst_word1_kept", {16'h0, dut.mem_q[0]}, 32'h1111);
    bus.ldValid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    check("arst_idle_ldReady", {31'h0, bus.ldReady}, 32'd0);
    start_and_clear();
    load_word(16'h0000, 1'b1);
    check("p3_procRst", {31'h0, o_procRst}, 32'd0);
    check("p3_edges", edges, 32'd66);
    rd(6'd0, 16'h0000, "p3_addr0_recleared");

    // Full-depth load ends at the last address without ldLast.
    @(negedge i_clk);
    start_and_clear();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("p4_pre_procRst", {31'h0, o_procRst}, 32'd1);
      load_word(16'h0100 + 16'(i), 1'b0);
    end
    check("p4_procRst", {31'h0, o_procRst}, 32'd0);
    check("p4_edges", edges, 32'd129);
    rd(6'd0, 16'h0100, "p4_addr0");
    rd(6'd63, 16'h013F, "p4_addr63");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
